// File: rtl/uc_multiciclo.sv
// Multicycle control unit: a four-state FSM (IDLE, FETCH, EXEC, HALT) that
// issues one instruction every two cycles. FETCH latches the opcode into ir;
// EXEC decodes ir together with the zero/carry flags into datapath controls.
// SKIPZ annuls the next instruction through an internal skip_pend flag.
//
// Configuration macro: UC_ILLEGAL_TRAP_EN
//   defined   -> a reserved opcode halts the machine (pc_en=0, -> HALT)
//   undefined -> a reserved opcode acts as a NOP (pc_en=1, -> FETCH)
// In both builds a reserved opcode sets the sticky illegal flag.
module uc_multiciclo (
  input  logic       clk,
  input  logic       reset,     // asynchronous, active-low
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       carry,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic       s_skip,
  output logic [2:0] alu_op,
  output logic       pc_en,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  localparam logic [5:0] OP_NOP = 6'b110000;

  state_t     state, next_state;
  logic [5:0] ir;
  logic       skip_pend;
  logic       is_reserved;
  logic       set_skip;

  // State register, instruction register, skip flag and sticky illegal flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ir        <= OP_NOP;
      skip_pend <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH) begin
        ir <= opcode;
      end
      if (state == ST_EXEC) begin
        // An annulled instruction only consumes the pending skip.
        skip_pend <= skip_pend ? 1'b0 : set_skip;
        if (is_reserved) begin
          illegal <= 1'b1;
        end
      end
    end
  end

  // Next-state and control decode; outputs depend on state, ir and flags.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    s_inc       = 1'b0;
    s_inm       = 1'b0;
    we          = 1'b0;
    s_skip      = 1'b0;
    alu_op      = 3'b000;
    pc_en       = 1'b0;
    halted      = 1'b0;
    is_reserved = 1'b0;
    set_skip    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        s_inc = 1'b1;
        if (start) begin
          next_state = ST_FETCH;
        end
      end

      ST_FETCH: begin
        s_inc      = 1'b1;
        next_state = ST_EXEC;
      end

      ST_EXEC: begin
        s_inc      = 1'b1;
        pc_en      = 1'b1;
        next_state = ST_FETCH;
        if (skip_pend) begin
          // Annulled slot: no write, sequential PC, flags ignored.
          s_skip = 1'b1;
        end else begin
          unique case (ir[5:4])
            2'b00: begin
              alu_op = ir[2:0];
              we     = 1'b1;
            end
            2'b01: begin
              we    = 1'b1;
              s_inm = 1'b1;
            end
            2'b10: begin
              unique case (ir[3:0])
                4'b0000: s_inc = 1'b0;     // J
                4'b0001: s_inc = ~zero;    // JZ
                4'b0010: s_inc = zero;     // JNZ
                4'b0011: s_inc = ~carry;   // JC
                default: is_reserved = 1'b1;
              endcase
            end
            default: begin
              unique case (ir[3:0])
                4'b0000: ;                 // NOP
                4'b0001: set_skip = zero;  // SKIPZ
                4'b1111: next_state = ST_HALT;
                default: is_reserved = 1'b1;
              endcase
            end
          endcase
`ifdef UC_ILLEGAL_TRAP_EN
          if (is_reserved) begin
            pc_en      = 1'b0;
            next_state = ST_HALT;
          end
`endif
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, release sampled on clk.
REQ-003 start  input  1  run request; sampled only in IDLE.
REQ-004 opcode  input  6  instruction opcode from datapath instruction memory.
REQ-005 zero  input  1  datapath zero flag.
REQ-006 carry  input  1  datapath carry flag.
REQ-007 s_inc  output  1  1 = PC+1, 0 = PC = jump address.
REQ-008 s_inm  output  1  1 = write-back immediate, 0 = write-back ALU result.
REQ-009 we  output  1  register-file write enable.
REQ-010 s_skip  output  1  high during EXEC of an annulled (skipped) instruction.
REQ-011 alu_op  output  3  ALU operation select.
REQ-012 pc_en  output  1  PC load enable; high only in EXEC.
REQ-013 halted  output  1  high while in HALT.
REQ-014 illegal  output  1  sticky, set on a reserved opcode.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, EXEC, HALT.
REQ-016 IDLE: start=1 -> FETCH; else stay.
REQ-017 FETCH: opcode latched into internal ir; all outputs 0 except s_inc=1; -> EXEC next cycle.
REQ-018 EXEC: outputs decoded combinationally from ir, zero, carry; pc_en=1 for exactly one cycle; -> FETCH, or HALT on halt/trap.
REQ-019 Throughput SHALL be one instruction per 2 cycles; no stalls.
REQ-020 ir[5:4]=00 ALU: alu_op=ir[2:0], we=1, s_inm=0, s_inc=1.
REQ-021 ir[5:4]=01 LI: we=1, s_inm=1, s_inc=1, alu_op=000.
REQ-022 ir=100000 J: s_inc=0, we=0.
REQ-023 ir=100001 JZ / 100010 JNZ / 100011 JC: s_inc=0 when taken (zero=1 / zero=0 / carry=1), else s_inc=1; we=0.
REQ-024 ir=110000 NOP: s_inc=1, we=0.
REQ-025 ir=110001 SKIPZ: s_inc=1, we=0; if zero=1, internal skip_pend set at end of EXEC.
REQ-026 ir=111111 HALT: s_inc=1, pc_en=1, then -> HALT.
REQ-027 All other opcodes reserved: illegal set at end of EXEC; handling per REQ-036/037.
REQ-028 skip_pend=1 at next EXEC: instruction annulled -> we=0, s_inc=1, s_skip=1, flags ignored, skip_pend cleared; an annulled HALT/SKIPZ/reserved opcode has no effect.
REQ-029 HALT: all control outputs 0, pc_en=0, halted=1; exit only via reset; start ignored.
REQ-030 Outputs not listed for an instruction SHALL be 0.

Reset
REQ-031 reset=0 -> state=IDLE, ir=110000, skip_pend=0, illegal=0, halted=0, within the same cycle, no clock required.
REQ-032 Output reset values: s_inc=1, s_inm=0, we=0, s_skip=0, alu_op=000, pc_en=0.
REQ-033 Reset asserted mid-EXEC SHALL drop we and pc_en immediately (asynchronous).
REQ-034 After release, first FETCH no earlier than the cycle after start=1 is sampled in IDLE.

Configuration
REQ-035 Macro UC_ILLEGAL_TRAP_EN selects reserved-opcode handling.
REQ-036 Defined: reserved opcode behaves as HALT (pc_en=0, -> HALT) and sets illegal.
REQ-037 Undefined: reserved opcode behaves as NOP (pc_en=1, -> FETCH) and sets illegal.

Verification
REQ-038 reset=0 at t=3 ns, start=1 -> IDLE, FETCH, EXEC; opcode=000011 -> EXEC: we=1, alu_op=011, s_inm=0, s_inc=1, pc_en=1.
REQ-039 opcode=100001 with zero=1 -> s_inc=0; repeat with zero=0 -> s_inc=1; we=0 in both.
REQ-040 SKIPZ with zero=1, then LI -> LI EXEC: we=0, s_skip=1; following LI EXEC: we=1, s_inm=1.
REQ-041 opcode=111111 -> pc_en=1 one cycle, then halted=1, outputs 0; start pulses ignored until reset.
REQ-042 opcode=101111: macro defined -> halted=1, illegal=1, pc_en=0; undefined -> pc_en=1, back to FETCH, illegal=1.
REQ-043 reset=0 mid-EXEC of ALU op -> we=0, pc_en=0 before next clk edge; state IDLE after release.
